adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered two-operand adder among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, pushes the operands through a two-stage pipeline (operand register, then sum register), and returns the `ADDER_WIDTH+1`-bit sum tagged with the requester index on a single back-pressurable response port. It sits between the requesting datapaths and the adder resource and is the only path to that adder.

---
 rtl/adder_arbiter.sv | 145 ++++++++++++++
 tb/tb_adder_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Shares one registered two-operand adder among NUM_REQ valid/ready requesters (S1 operands, S2 sum).
// Define ADDER_ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest asserted index always wins.
module adder_arbiter #(
    parameter int unsigned ADDER_WIDTH = 5,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_WIDTH    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [ADDER_WIDTH:0]           resp_sum,
    output logic [ID_WIDTH-1:0]            resp_id
);

    localparam int unsigned SUM_W = ADDER_WIDTH + 1;

    logic                   advance_c;
    logic                   win_found_c;
    int                     win_idx_c;
    logic [ID_WIDTH-1:0]    win_id_c;
    logic [ID_WIDTH-1:0]    ptr_c;
    logic [NUM_REQ-1:0]     rot_c;
    logic [ADDER_WIDTH-1:0] win_a_c;
    logic [ADDER_WIDTH-1:0] win_b_c;

    logic                   s1_valid_q, s1_valid_d;
    logic [ADDER_WIDTH-1:0] s1_a_q, s1_a_d;
    logic [ADDER_WIDTH-1:0] s1_b_q, s1_b_d;
    logic [ID_WIDTH-1:0]    s1_id_q, s1_id_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [SUM_W-1:0]       resp_sum_q, resp_sum_d;
    logic [ID_WIDTH-1:0]    resp_id_q, resp_id_d;

    assign advance_c = !resp_valid_q || resp_ready;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    int                  ptr_nxt_c;

    assign ptr_c = ptr_q;
    // Rotate so that bit 0 of rot_c is requester ptr; search then starts there.
    assign rot_c = NUM_REQ'({req_valid, req_valid} >> ptr_q);

    always_comb begin
        ptr_nxt_c = win_idx_c + 1;
        if (ptr_nxt_c >= int'(NUM_REQ)) begin
            ptr_nxt_c = 0;
        end
        ptr_d = ptr_q;
        if (advance_c && win_found_c) begin
            ptr_d = ID_WIDTH'(ptr_nxt_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ptr_c = '0;
    assign rot_c = req_valid;
`endif

    // First set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (rot_c[k]) begin
                win_found_c = 1'b1;
                win_idx_c   = int'(ptr_c) + k;
            end
        end
        if (win_idx_c >= int'(NUM_REQ)) begin
            win_idx_c = win_idx_c - int'(NUM_REQ);
        end
        win_id_c = ID_WIDTH'(win_idx_c);
    end

    always_comb begin
        win_a_c   = '0;
        win_b_c   = '0;
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_id_c == ID_WIDTH'(i)) begin
                win_a_c = req_a[i*ADDER_WIDTH +: ADDER_WIDTH];
                win_b_c = req_b[i*ADDER_WIDTH +: ADDER_WIDTH];
            end
            req_ready[i] = advance_c && win_found_c && !reset && (win_id_c == ID_WIDTH'(i));
        end
    end

    // Whole pipeline moves together only when the response slot is free or being drained.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_id_d      = s1_id_q;
        resp_valid_d = resp_valid_q;
        resp_sum_d   = resp_sum_q;
        resp_id_d    = resp_id_q;
        if (advance_c) begin
            s1_valid_d   = win_found_c;
            s1_a_d       = win_a_c;
            s1_b_d       = win_b_c;
            s1_id_d      = win_id_c;
            resp_valid_d = s1_valid_q;
            resp_sum_d   = SUM_W'(s1_a_q) + SUM_W'(s1_b_q);
            resp_id_d    = s1_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_sum_q   <= '0;
            resp_id_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            resp_valid_q <= resp_valid_d;
            resp_sum_q   <= resp_sum_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_sum   = resp_sum_q;
    assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (default parameters); expectations follow ADDER_ARB_ROUND_ROBIN_EN.
module tb_adder_arbiter;

    localparam int W  = 5;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [W:0]     resp_sum;
    logic [IW-1:0]  resp_id;

    int n_checks = 0;
    int n_fail   = 0;

    adder_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N), .ID_WIDTH(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    int exp_rr[8];
    int exp_wrap[4];
    int rr_sum[4];
    int wrap_sum[4];
    int k;
    int got;

    initial begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
        exp_rr   = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_wrap = '{3, 0, 3, 0};
`else
        exp_rr   = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_wrap = '{0, 0, 0, 0};
`endif
        rr_sum   = '{25, 27, 29, 31};
        wrap_sum = '{33, 0, 0, 32};

        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // Reset for two edges, with requests asserted to prove ready stays low.
        for (int c = 0; c < 2; c++) begin
            cyc();
            req_valid = 4'hF;
            #1;
            check("rst_ready", 32'(req_ready), 0);
            check("rst_valid", 32'(resp_valid), 0);
            check("rst_sum", 32'(resp_sum), 0);
            check("rst_id", 32'(resp_id), 0);
        end
        reset     = 1'b0;
        req_valid = '0;

        for (int c = 0; c < 5; c++) begin
            cyc();
            #1;
            check("idle_valid", 32'(resp_valid), 0);
            check("idle_sum", 32'(resp_sum), 0);
            check("idle_id", 32'(resp_id), 0);
            check("idle_ready", 32'(req_ready), 0);
        end

        // All requesters continuously valid for eight grants.
        for (int i = 0; i < N; i++) set_op(i, W'(5 + i), W'(20 + i));
        for (int c = 0; c < 11; c++) begin
            cyc();
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) check("rr_ready", 32'(req_ready), 32'(1) << exp_rr[c]);
            else       check("rr_ready_off", 32'(req_ready), 0);
            if (c >= 2 && c < 10) begin
                check("rr_valid", 32'(resp_valid), 1);
                check("rr_id", 32'(resp_id), 32'(exp_rr[c-2]));
                check("rr_sum", 32'(resp_sum), 32'(rr_sum[exp_rr[c-2]]));
            end
            if (c == 10) check("rr_drain", 32'(resp_valid), 0);
        end

        // Single request: requester 2, 31 + 31.
        cyc();
        set_op(2, 5'd31, 5'd31);
        req_valid = 4'b0100;
        #1;
        check("one_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        #1;
        check("one_valid_s1", 32'(resp_valid), 0);
        cyc();
        #1;
        check("one_valid", 32'(resp_valid), 1);
        check("one_sum", 32'(resp_sum), 62);
        check("one_id", 32'(resp_id), 2);
        cyc();
        #1;
        check("one_done", 32'(resp_valid), 0);

        // Back-pressure: requester 1 streams k + 1, consumer stalls for cycles 3..6.
        k   = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            cyc();
            resp_ready = !(c >= 3 && c <= 6);
            req_valid  = (k < 8) ? 4'b0010 : 4'b0000;
            set_op(1, W'(k), 5'd1);
            #1;
            if (c >= 3 && c <= 6) check("bp_stall_ready", 32'(req_ready), 0);
            if (resp_valid && resp_ready) begin
                check("bp_sum", 32'(resp_sum), 32'(got + 1));
                check("bp_id", 32'(resp_id), 1);
                got++;
            end
            if (req_ready[1]) k++;
        end
        check("bp_count", 32'(got), 8);
        check("bp_accepted", 32'(k), 8);
        resp_ready = 1'b1;
        cyc();
        #1;
        check("bp_no_dup", 32'(resp_valid), 0);

        // Reset with two results in flight.
        cyc();
        req_valid = 4'b0010;
        set_op(1, 5'd10, 5'd3);
        #1;
        check("mid_ready0", 32'(req_ready), 32'h2);
        cyc();
        set_op(1, 5'd11, 5'd3);
        #1;
        check("mid_ready1", 32'(req_ready), 32'h2);
        cyc();
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_inflight", 32'(resp_sum), 13);
        cyc();
        reset     = 1'b0;
        req_valid = '0;
        #1;
        check("mid_post_valid", 32'(resp_valid), 0);
        check("mid_post_sum", 32'(resp_sum), 0);
        check("mid_post_id", 32'(resp_id), 0);
        cyc();
        #1;
        check("mid_discard", 32'(resp_valid), 0);
        cyc();
        req_valid = 4'b1010;
        set_op(1, 5'd20, 5'd9);
        set_op(3, 5'd1, 5'd1);
        #1;
        check("mid_ptr0", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        #1;
        check("mid_new_s1", 32'(resp_valid), 0);
        cyc();
        #1;
        check("mid_new_valid", 32'(resp_valid), 1);
        check("mid_new_sum", 32'(resp_sum), 29);
        check("mid_new_id", 32'(resp_id), 1);
        cyc();
        #1;
        check("mid_new_done", 32'(resp_valid), 0);

        // Only requesters 3 and 0 valid: pointer wraps from 3 to 0.
        set_op(3, 5'd30, 5'd2);
        set_op(0, 5'd17, 5'd16);
        for (int c = 0; c < 7; c++) begin
            cyc();
            req_valid = (c < 4) ? 4'b1001 : 4'b0000;
            #1;
            if (c < 4) check("wrap_ready", 32'(req_ready), 32'(1) << exp_wrap[c]);
            if (c >= 2 && c < 6) begin
                check("wrap_valid", 32'(resp_valid), 1);
                check("wrap_id", 32'(resp_id), 32'(exp_wrap[c-2]));
                check("wrap_sum", 32'(resp_sum), 32'(wrap_sum[exp_wrap[c-2]]));
            end
            if (c == 6) check("wrap_drain", 32'(resp_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
